// File: rtl/tdm_demux_pkg.sv
// tdm_pkg: shared TDM link types and helpers (state enum, slot-index width, even parity)
package tdm_pkg;
    typedef enum logic {HUNT, RUN} state_t;
    function automatic int slot_w(input int channels);
        return $clog2(channels);
    endfunction
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/tdm_demux_if.sv
// tdm_demux_if: lane input and published frame of the TDM demultiplexer; TDM_DEMUX_PARITY_EN adds a parity MSB to din
interface tdm_demux_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
);
`ifdef TDM_DEMUX_PARITY_EN
    localparam int DIN_W = WIDTH + 1;
`else
    localparam int DIN_W = WIDTH;
`endif
    logic                      din_valid;
    logic [DIN_W-1:0]          din;
    logic                      frame_sync;
    logic [CHANNELS*WIDTH-1:0] dout;
    logic                      frame_valid;
    logic                      locked;
    logic                      sync_err;
    logic                      parity_err;
    modport master (
        output din_valid, din, frame_sync,
        input  dout, frame_valid, locked, sync_err, parity_err
    );
    modport slave (
        input  din_valid, din, frame_sync,
        output dout, frame_valid, locked, sync_err, parity_err
    );
endinterface

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: slot index within a frame, with sync-load-to-1, clear and exact wrap at CHANNELS-1
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SW       = slot_w(CHANNELS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          load1,
    input  logic          clr,
    output logic [SW-1:0] slot,
    output logic          last_slot
);
    assign last_slot = slot == SW'(CHANNELS - 1);
    // clear beats sync-load, which beats a plain advance
    always_ff @(posedge clk) begin
        if (!rst_n || clr) slot <= '0;
        else if (load1) slot <= SW'(1);
        else if (en) slot <= last_slot ? '0 : slot + SW'(1);
    end
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: TDM lane demultiplexer locking on frame_sync and publishing whole frames; TDM_DEMUX_PARITY_EN enables per-word parity checking
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input logic        clk,
    input logic        rst_n,
    tdm_demux_if.slave bus
);
    localparam int SW = slot_w(CHANNELS);
    state_t                    state, state_nxt;
    logic [SW-1:0]             slot, wr_idx;
    logic                      last_slot;
    logic                      accept, load1, clr, adv, pub_slot, serr;
    logic                      frame_ok;
    logic [WIDTH-1:0]          word;
    logic [WIDTH-1:0]          shadow [CHANNELS-1];
    logic [CHANNELS*WIDTH-1:0] frame;
    assign word = bus.din[WIDTH-1:0];
    assign bus.locked = state == RUN;
    tdm_slot_counter #(.CHANNELS(CHANNELS)) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (adv),
        .load1     (load1),
        .clr       (clr),
        .slot      (slot),
        .last_slot (last_slot)
    );
    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= HUNT;
        else state <= state_nxt;
    end
    // lock on a sync word in HUNT, drop lock when slot 0 arrives without sync
    always_comb begin
        state_nxt = state;
        if (bus.din_valid && state == HUNT && bus.frame_sync) state_nxt = RUN;
        else if (bus.din_valid && state == RUN && !bus.frame_sync && slot == '0) state_nxt = HUNT;
    end
    // per-word controls: a sync word always restarts at slot 0, early sync and missing sync are framing errors
    always_comb begin
        accept   = bus.din_valid && (bus.frame_sync || (state == RUN && slot != '0));
        load1    = bus.din_valid && bus.frame_sync;
        clr      = bus.din_valid && state == RUN && !bus.frame_sync && slot == '0;
        adv      = accept && !bus.frame_sync;
        pub_slot = adv && last_slot;
        serr     = clr || (load1 && state == RUN && slot != '0);
        wr_idx   = bus.frame_sync ? '0 : slot;
    end
    // shadow holds slots 0..CHANNELS-2; the last slot goes straight to dout from the lane
    always_ff @(posedge clk) begin
        for (int k = 0; k < CHANNELS - 1; k++) begin
            if (!rst_n) shadow[k] <= '0;
            else if (accept && wr_idx == SW'(k)) shadow[k] <= word;
        end
    end
    // assemble the frame that would be published by the current last-slot word
    always_comb begin
        frame = '0;
        for (int k = 0; k < CHANNELS - 1; k++) frame[k*WIDTH +: WIDTH] = shadow[k];
        frame[(CHANNELS-1)*WIDTH +: WIDTH] = word;
    end
    // publish path and registered framing-error pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.dout        <= '0;
            bus.frame_valid <= 1'b0;
            bus.sync_err    <= 1'b0;
        end else begin
            bus.frame_valid <= pub_slot && frame_ok;
            bus.sync_err    <= serr;
            if (pub_slot && frame_ok) bus.dout <= frame;
        end
    end
`ifdef TDM_DEMUX_PARITY_EN
    logic pbad, frame_bad;
    assign pbad     = accept && (even_parity(64'(word)) != bus.din[WIDTH]);
    assign frame_ok = !(frame_bad || pbad);
    // a parity miss on any accepted word poisons the frame until the next sync word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_bad      <= 1'b0;
            bus.parity_err <= 1'b0;
        end else begin
            bus.parity_err <= pbad;
            if (load1) frame_bad <= pbad;
            else if (accept) frame_bad <= frame_bad || pbad;
        end
    end
`else
    assign frame_ok       = 1'b1;
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: scoreboard bench for tdm_demux; covers parity scenarios when TDM_DEMUX_PARITY_EN is defined
module tb_tdm_demux;
    localparam int CH = 4;
    localparam int W  = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int DW = W + 1;
`else
    localparam int DW = W;
`endif
    typedef struct {
        logic [CH*W-1:0] data;
        int              at;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   fv_cnt = 0;
    int   serr_cnt = 0;
    int   perr_cnt = 0;
    int   s0;
    int   p0;
    exp_t sb[$];
    exp_t e;
    tdm_demux_if #(.CHANNELS(CH), .WIDTH(W)) bus ();
    tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask
    // every published frame must match the oldest expected frame, in the expected cycle
    always @(negedge clk) begin
        if (bus.frame_valid) begin
            fv_cnt++;
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("dout", bus.dout, e.data);
                check("fv_cycle", cyc, e.at);
            end
        end
        if (bus.sync_err) serr_cnt++;
        if (bus.parity_err) perr_cnt++;
    end
    function automatic logic [DW-1:0] enc(input logic [W-1:0] w);
`ifdef TDM_DEMUX_PARITY_EN
        return {^w, w};
`else
        return w;
`endif
    endfunction
    task automatic send_raw(input logic [DW-1:0] d, input logic s, input int gap);
        bus.din_valid  = 1'b1;
        bus.din        = d;
        bus.frame_sync = s;
        @(posedge clk); #1;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask
    task automatic send(input logic [W-1:0] w, input logic s);
        send_raw(enc(w), s, 0);
    endtask
    task automatic frame(input logic [CH*W-1:0] f, input int gap, input bit pub);
        for (int k = 0; k < CH; k++) begin
            if (k == CH - 1 && pub) sb.push_back('{data: f, at: cyc + 1});
            send_raw(enc(f[k*W +: W]), k == 0, gap);
        end
    endtask
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    initial begin
        bus.din_valid  = 1'b0;
        bus.din        = '0;
        bus.frame_sync = 1'b0;
        idle(2);
        check("rst_dout", bus.dout, 0);
        check("rst_fv", bus.frame_valid, 0);
        check("rst_locked", bus.locked, 0);
        check("rst_serr", bus.sync_err, 0);
        check("rst_perr", bus.parity_err, 0);
        rst_n = 1'b1;
        idle(1);
        frame(32'h44332211, 0, 1);
        idle(2);
        check("normal_dout", bus.dout, 32'h44332211);
        check("normal_locked", bus.locked, 1);
        check("normal_fv_cnt", fv_cnt, 1);
        frame(32'h44332211, 3, 1);
        idle(2);
        check("gaps_dout", bus.dout, 32'h44332211);
        check("gaps_fv_cnt", fv_cnt, 2);
        s0 = serr_cnt;
        send(8'hAA, 1);
        send(8'hBB, 0);
        frame(32'h04030201, 0, 1);
        idle(2);
        check("early_serr", serr_cnt - s0, 1);
        check("early_dout", bus.dout, 32'h04030201);
        check("early_locked", bus.locked, 1);
        check("early_fv_cnt", fv_cnt, 3);
        s0 = serr_cnt;
        send(8'h55, 0);
        check("miss_serr_pulse", bus.sync_err, 1);
        check("miss_locked", bus.locked, 0);
        idle(1);
        check("miss_serr", serr_cnt - s0, 1);
        check("miss_dout", bus.dout, 32'h04030201);
        send(8'h66, 0);
        send(8'h77, 0);
        idle(1);
        check("hunt_locked", bus.locked, 0);
        check("hunt_serr", serr_cnt - s0, 1);
        frame(32'hD4C3B2A1, 0, 1);
        idle(2);
        check("relock_locked", bus.locked, 1);
        check("relock_dout", bus.dout, 32'hD4C3B2A1);
        check("relock_fv_cnt", fv_cnt, 4);
        frame(32'h13579BDF, 0, 1);
        frame(32'h2468ACE0, 0, 1);
        idle(2);
        check("b2b_dout", bus.dout, 32'h2468ACE0);
        check("b2b_fv_cnt", fv_cnt, 6);
        send(8'h01, 1);
        send(8'h02, 0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check("midrst_dout", bus.dout, 0);
        check("midrst_locked", bus.locked, 0);
        check("midrst_fv", bus.frame_valid, 0);
        check("midrst_serr", bus.sync_err, 0);
        send(8'h12, 0);
        send(8'h34, 0);
        send(8'h56, 0);
        send(8'h78, 0);
        idle(2);
        check("postrst_locked", bus.locked, 0);
        check("postrst_dout", bus.dout, 0);
        check("postrst_fv_cnt", fv_cnt, 6);
        frame(32'h40302010, 0, 1);
        idle(2);
        check("postrst_relock", bus.dout, 32'h40302010);
        check("postrst_fv_cnt2", fv_cnt, 7);
        s0 = serr_cnt;
        send(8'hE1, 1);
        send(8'hE2, 0);
        send(8'hE3, 0);
        frame(32'h8C8B8A89, 0, 1);
        idle(2);
        check("lastslot_serr", serr_cnt - s0, 1);
        check("lastslot_dout", bus.dout, 32'h8C8B8A89);
        check("lastslot_fv_cnt", fv_cnt, 8);
`ifdef TDM_DEMUX_PARITY_EN
        p0 = perr_cnt;
        send(8'h91, 1);
        send(8'h92, 0);
        send_raw({~(^8'h93), 8'h93}, 0, 0);
        send(8'h94, 0);
        idle(2);
        check("par_perr", perr_cnt - p0, 1);
        check("par_fv_cnt", fv_cnt, 8);
        check("par_dout", bus.dout, 32'h8C8B8A89);
        check("par_locked", bus.locked, 1);
        frame(32'hA4A3A2A1, 0, 1);
        idle(2);
        check("par_clean_dout", bus.dout, 32'hA4A3A2A1);
        check("par_clean_fv_cnt", fv_cnt, 9);
        check("par_clean_perr", perr_cnt - p0, 1);
`else
        p0 = perr_cnt;
        check("noparity_perr", p0, 0);
`endif
        idle(3);
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive end of the team's TDM multiplexer link. It accepts one word per valid cycle from a single shared lane and locks onto the frame using a sync marker. It then distributes slot k of each frame to output channel k, and publishes all channels atomically once per completed frame. It sits after the serial/lane receiver and feeds the per-channel consumers.

## Interface
- CHANNELS, default 4: slots per frame (≥2).
- WIDTH, default 8: bits per slot word.
- clk  input  1  rising-edge clock; the single clock of the block.
- rst_n  input  1  reset, synchronous, active-low.
- din_valid  input  1  din/frame_sync qualified this cycle.
- din  input  WIDTH (WIDTH+1 with TDM_DEMUX_PARITY_EN)  slot word; MSB is even-parity bit when parity is enabled.
- frame_sync  input  1  marks the current word as slot 0; ignored when din_valid=0.
- dout  output  CHANNELS*WIDTH  published frame; channel k at bits [k*WIDTH +: WIDTH].
- frame_valid  output  1  one-cycle pulse when dout is updated.
- locked  output  1  high in RUN state.
- sync_err  output  1  one-cycle pulse on framing error.
- parity_err  output  1  one-cycle pulse on parity mismatch (only with TDM_DEMUX_PARITY_EN).

## Operation
- States: HUNT (reset state), RUN.
- **HUNT**:
  - Words without sync are discarded.
  - A valid word with frame_sync=1 is stored as slot 0.
  - Slot counter goes to 1; state goes to RUN.
- **RUN**: each valid word is stored in shadow register [slot], then the slot counter increments.
  - Slot CHANNELS-1 accepted: shadow plus last word copied to dout, frame_valid pulses, counter wraps to 0.
  - Valid word at slot 0 with frame_sync=1: normal frame start.
  - Valid word at slot 0 with frame_sync=0: sync_err pulses, word discarded, state returns to HUNT.
  - frame_sync=1 at slot ≠0: sync_err pulses, partial frame dropped (dout unchanged, no frame_valid), word taken as the new slot 0, stays in RUN.
- din_valid=0 cycles stall the counter; gaps of any length inside a frame are legal.
- Shadow registers are not cleared between frames; dout holds its value until the next complete frame.
- Slot counter width is $clog2(CHANNELS); comparisons against CHANNELS-1 are exact, with no wrap beyond CHANNELS-1.

## Timing
- Inputs are sampled on the rising edge of clk.
- Latency: dout and frame_valid update on the clock edge that samples the last slot word. They are visible in the cycle after that word is presented (1-cycle latency).
- sync_err and parity_err are registered: they pulse in the cycle after the offending word.
- locked rises in the cycle after the sync word is accepted in HUNT. It falls in the cycle after a missing-sync error.
- Reset values when rst_n=0 at a clock edge: dout=0, frame_valid=0, locked=0, sync_err=0, parity_err=0, state=HUNT, counter=0, shadow=0.
- Reset mid-frame discards the partial frame; reset has priority over all inputs.

## Configuration
- TDM_DEMUX_PARITY_EN defined:
  - din is WIDTH+1 bits; bit WIDTH carries even parity over din[WIDTH-1:0].
  - A mismatch on an accepted word pulses parity_err and marks the frame bad.
  - A bad frame is dropped at completion: dout unchanged, no frame_valid, lock kept.
  - Parity is not checked in HUNT except on the sync word itself.
- TDM_DEMUX_PARITY_EN undefined:
  - din is WIDTH bits.
  - parity_err is tied to 0.
  - No checking logic is present.

## Structure
- Package tdm_pkg holds:
  - the state enum (HUNT, RUN);
  - the localparam function for slot-index width;
  - the even-parity function, shared with the multiplexer transmitter.
- One sub-module, tdm_slot_counter. It provides enable, sync-load-to-1, clear and wrap at CHANNELS-1, and outputs slot index and last_slot.
- Shadow registers, the publish path and the FSM stay in tdm_demux.

## Test plan
- **Normal frame.** Stimulus: CHANNELS=4, WIDTH=8; after reset, send 0x11(sync), 0x22, 0x33, 0x44. Required: dout=0x44332211, one frame_valid pulse, locked=1.
- **Gaps.** Stimulus: same frame with din_valid=0 for 3 cycles between every word. Required: identical dout, exactly one frame_valid, pulse one cycle after 0x44.
- **Early sync.** Stimulus: sync 0xAA, 0xBB, then sync 0x01, 0x02, 0x03, 0x04. Required: one sync_err pulse, dout=0x04030201, locked stays 1.
- **Missing sync.** Stimulus: after a good frame, send 0x55 without sync at slot 0. Required: sync_err pulse, locked=0, dout unchanged; next sync frame relocks.
- **Reset mid-frame.** Stimulus: rst_n=0 for one edge after two words of a frame. Required: all outputs 0, locked=0; words without sync are ignored after reset.
- **Parity (macro on).** Stimulus: frame with bad parity on slot 2. Required: parity_err pulse, no frame_valid, dout unchanged; next clean frame publishes.
